// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data memory responder for the pipeline MEM stage
// Optional MISALIGN_TRAP_EN: trap word-misaligned accesses and expose the err port.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  count;
  logic        op_wr_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        req_rd, req_wr;
  logic        access;
  logic        acc_wr;
  logic [31:0] acc_addr;
  logic [31:0] acc_data;
  logic        acc_mis;
  logic [AW-1:0] acc_idx;

  logic [31:0] mem [DEPTH_WORDS];

  // if() takes the else path on X/Z, so unknown requests read as idle
  always_comb begin
    req_rd = 1'b0;
    req_wr = 1'b0;
    if (mem_read)  req_rd = 1'b1;
    if (mem_write) req_wr = 1'b1;
  end

  always_comb begin
    state_next = state;
    access     = 1'b0;
    acc_wr     = op_wr_q;
    acc_addr   = addr_q;
    acc_data   = data_q;
    case (state)
      IDLE: begin
        if (req_rd || req_wr) begin
          if (WAIT_CYCLES == 0) begin
            state_next = DONE;
            access     = 1'b1;
            acc_wr     = req_wr;
            acc_addr   = addr;
            acc_data   = write_data;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (count <= 4'd1) begin
          state_next = DONE;
          access     = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign acc_idx = acc_addr[AW+1:2];

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign acc_mis = (acc_addr[1:0] != 2'b00);
  assign err     = (state == DONE) && mis_q;
`else
  assign acc_mis = 1'b0;
`endif

  // Upper address bits wrap and, without the trap, byte offset is ignored
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, acc_addr[31:AW+2], acc_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 4'd0;
      read_data <= 32'd0;
      op_wr_q   <= 1'b0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE && (req_rd || req_wr)) begin
        op_wr_q <= req_wr;
        addr_q  <= addr;
        data_q  <= write_data;
        count   <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end
      if (access) begin
        if (acc_mis)      read_data <= 32'd0;
        else if (!acc_wr) read_data <= mem[acc_idx];
`ifdef MISALIGN_TRAP_EN
        mis_q <= acc_mis;
`endif
      end
    end
  end

  // Array is never cleared; reset only blocks a commit on the same edge
  always_ff @(posedge clk) begin
    if (!rst && access && acc_wr && !acc_mis)
      mem[acc_idx] <= acc_data;
  end

  assign ready = (state == DONE);
  assign busy  = !rst && ((state == WAIT) || (state == IDLE && (req_rd || req_wr)));

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (WAIT_CYCLES 0 and 2)
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_rd   [2];
  logic        in_wr   [2];
  logic [31:0] in_a    [2];
  logic [31:0] in_d    [2];
  logic [31:0] o_rdata [2];
  logic        o_ready [2];
  logic        o_busy  [2];
`ifdef MISALIGN_TRAP_EN
  logic        o_err   [2];
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem_m [2][256];
  logic [31:0] last  [2];

  always #5 clk = ~clk;

  // index 0: zero wait states, index 1: two wait states
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_read(in_rd[0]), .mem_write(in_wr[0]),
    .addr(in_a[0]), .write_data(in_d[0]), .read_data(o_rdata[0]),
    .ready(o_ready[0]), .busy(o_busy[0])
`ifdef MISALIGN_TRAP_EN
    , .err(o_err[0])
`endif
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .mem_read(in_rd[1]), .mem_write(in_wr[1]),
    .addr(in_a[1]), .write_data(in_d[1]), .read_data(o_rdata[1]),
    .ready(o_ready[1]), .busy(o_busy[1])
`ifdef MISALIGN_TRAP_EN
    , .err(o_err[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    in_rd[sel] = rd;
    in_wr[sel] = wr;
    in_a[sel]  = a;
    in_d[sel]  = d;
  endtask

  // Called just after a falling edge with the DUT idle; returns one cycle after DONE
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    int w;
    int busy_cnt;
    int ready_at;
    int idx;
    logic mis;
    logic [31:0] exp_rd;
    logic [31:0] got_exp;
    w        = (sel == 0) ? 0 : 2;
    busy_cnt = 0;
    ready_at = -1;
    idx      = int'(a[9:2]);
`ifdef MISALIGN_TRAP_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (mis) begin
      exp_rd = 32'd0;
      last[sel] = 32'd0;
    end else if (wr) begin
      mem_m[sel][idx] = d;
      exp_rd = last[sel];
    end else begin
      exp_rd = mem_m[sel][idx];
      last[sel] = exp_rd;
    end
    exp_q.push_back(exp_rd);

    drive(sel, rd, wr, a, d);
    #1;
    if (o_busy[sel]) busy_cnt++;
    @(posedge clk);
    for (int k = 1; k <= 20 && ready_at < 0; k++) begin
      @(negedge clk);
      if (o_busy[sel]) busy_cnt++;
      if (o_ready[sel]) begin
        ready_at = k;
`ifdef MISALIGN_TRAP_EN
        check({tag, "_err"}, {31'd0, o_err[sel]}, {31'd0, mis});
`endif
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
      end
    end
    if (ready_at < 0) drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    check({tag, "_lat"}, 32'(ready_at), 32'(w + 1));
    check({tag, "_busy"}, 32'(busy_cnt), 32'(w + 1));
    got_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_rdata"}, o_rdata[sel], got_exp);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(i, 1'b0, 1'b0, 32'd0, 32'd0);
      last[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_rdata%0d", i), o_rdata[i], 32'd0);
      check($sformatf("rst_ready%0d", i), {31'd0, o_ready[i]}, 32'd0);
    end
    drive(1, 1'b1, 1'b0, 32'd0, 32'd0);
    #1;
    check("rst_busy_with_req", {31'd0, o_busy[1]}, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    access(1, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, "w2_wr10");
    access(1, 1'b1, 1'b0, 32'h10,  32'h0,        "w2_rd10");
    access(1, 1'b1, 1'b0, 32'h13,  32'h0,        "w2_rd13");
    access(1, 1'b1, 1'b1, 32'h20,  32'hA5A5A5A5, "w2_both20");
    access(1, 1'b1, 1'b0, 32'h20,  32'h0,        "w2_rd20");
    access(1, 1'b0, 1'b1, 32'h400, 32'h11,       "w2_wr400");
    access(1, 1'b1, 1'b0, 32'h0,   32'h0,        "w2_rd0_wrap");
    access(0, 1'b0, 1'b1, 32'h4,   32'h12345678, "w0_wr4");
    access(0, 1'b1, 1'b0, 32'h4,   32'h0,        "w0_rd4");

    repeat (3) @(negedge clk);
    check("idle_hold", o_rdata[1], last[1]);

    access(1, 1'b0, 1'b1, 32'h8, 32'h0BADF00D, "w2_wr8_old");
    drive(1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    check("mid_wait_busy", {31'd0, o_busy[1]}, 32'd1);
    check("mid_wait_ready", {31'd0, o_ready[1]}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", {31'd0, o_busy[1]}, 32'd0);
    check("midrst_rdata", o_rdata[1], 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    last[0] = 32'd0;
    last[1] = 32'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("midrst_no_ready%0d", k), {31'd0, o_ready[1]}, 32'd0);
    end
    access(1, 1'b1, 1'b0, 32'h8, 32'h0, "w2_rd8_after_rst");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
